// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix result streamer.
package matrix_pkg;

  localparam int unsigned ELEM_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Index width for a dimension of size n, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_result_streamer_if.sv
// Valid/ready element stream carrying a matrix element and its coordinates.
interface matrix_result_streamer_if
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS = 3,
  parameter int unsigned COLS = 6,
  parameter int unsigned W    = ELEM_W_DEF
);

  logic                      out_valid;
  logic                      out_ready;
  logic [W-1:0]              out_data;
  logic [idx_w(ROWS)-1:0]    out_row;
  logic [idx_w(COLS)-1:0]    out_col;
  logic                      out_last;

  modport master (
    output out_valid, out_data, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_col, out_last,
    output out_ready
  );

endinterface

// File: rtl/mat_index_counter.sv
// Row-major (row, col) position counter with column wrap and final-row flags.
module mat_index_counter
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS = 3,
  parameter int unsigned COLS = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   inc,
  output logic [idx_w(ROWS)-1:0] row,
  output logic [idx_w(COLS)-1:0] col,
  output logic                   wrap,
  output logic                   last
);

  localparam int unsigned RW = idx_w(ROWS);
  localparam int unsigned CW = idx_w(COLS);

  assign wrap = (col == CW'(COLS - 1));
  assign last = (row == RW'(ROWS - 1));

  // Advancing past the final element returns to (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (wrap) begin
        col <= '0;
        row <= last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/matrix_result_streamer.sv
// Captures a flat matrix on start and streams its elements row-major over a
// valid/ready interface, pulsing done after the final element is accepted.
module matrix_result_streamer
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS = 3,
  parameter int unsigned COLS = 6,
  parameter int unsigned W    = ELEM_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ROWS*COLS*W-1:0]  mat_in,
  output logic                    busy,
  output logic                    done,
  matrix_result_streamer_if.master strm
);

  localparam int unsigned RW = idx_w(ROWS);
  localparam int unsigned CW = idx_w(COLS);

  localparam logic [1:0] IDLE   = 2'(ST_IDLE);
  localparam logic [1:0] STREAM = 2'(ST_STREAM);
  localparam logic [1:0] DONE   = 2'(ST_DONE);

  logic [1:0]                       state;
  logic [1:0]                       state_nxt;
  logic [ROWS-1:0][COLS-1:0][W-1:0] cap;
  logic [RW-1:0]                    row;
  logic [CW-1:0]                    col;
  logic                             idx_wrap;
  logic                             idx_last;
  logic                             valid_q;
  logic                             capture_c;
  logic                             xfer_c;
  logic                             final_c;

  assign xfer_c  = valid_q & strm.out_ready;
  assign final_c = idx_wrap & idx_last;

  mat_index_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (capture_c),
    .inc   (xfer_c),
    .row   (row),
    .col   (col),
    .wrap  (idx_wrap),
    .last  (idx_last)
  );

  // Next-state and capture decision.
  always_comb begin
    state_nxt = state;
    capture_c = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = STREAM;
          capture_c = 1'b1;
        end
      end
      STREAM: begin
        if (xfer_c && final_c) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cap     <= '0;
    end else begin
      state   <= state_nxt;
      valid_q <= (state_nxt == STREAM);
      busy    <= (state_nxt == STREAM);
      done    <= (state_nxt == DONE);
      if (capture_c) begin
        cap <= mat_in;
      end
    end
  end

  // Element and coordinates decode from the capture and index registers, so
  // they hold while the index is not advancing.
  assign strm.out_valid = valid_q;
  assign strm.out_data  = cap[row][col];
  assign strm.out_row   = row;
  assign strm.out_col   = col;
  assign strm.out_last  = valid_q & final_c;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Self-checking bench: row-major reference queue for a 3x6 instance plus a
// vector table for a 1x1 instance.
module tb_matrix_result_streamer;
  import matrix_pkg::*;

  localparam int unsigned ROWS = 3;
  localparam int unsigned COLS = 6;
  localparam int unsigned W    = 8;
  localparam int unsigned N    = ROWS * COLS;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [N*W-1:0]   mat_in;
  logic             busy;
  logic             done;
  logic             start1;
  logic [W-1:0]     mat_in1;
  logic             busy1;
  logic             done1;

  logic [W-1:0]     ref_m [N];
  int               checks = 0;
  int               errors = 0;

  typedef struct {
    logic [W-1:0] din;
    int           stall;
    logic [W-1:0] exp_data;
    logic         exp_last;
  } vec_t;
  vec_t vecs [4];

  matrix_result_streamer_if #(.ROWS(ROWS), .COLS(COLS), .W(W)) bus ();
  matrix_result_streamer_if #(.ROWS(1), .COLS(1), .W(W)) bus1 ();

  matrix_result_streamer #(.ROWS(ROWS), .COLS(COLS), .W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mat_in (mat_in),
    .busy   (busy),
    .done   (done),
    .strm   (bus.master)
  );

  matrix_result_streamer #(.ROWS(1), .COLS(1), .W(W)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start1),
    .mat_in (mat_in1),
    .busy   (busy1),
    .done   (done1),
    .strm   (bus1.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mat();
    for (int k = 0; k < int'(N); k++) mat_in[k*W +: W] = ref_m[k];
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(bus.out_valid), 0);
    chk({tag, "_busy"},  64'(busy), 0);
    chk({tag, "_done"},  64'(done), 0);
    chk({tag, "_last"},  64'(bus.out_last), 0);
    chk({tag, "_data"},  64'(bus.out_data), 0);
    chk({tag, "_row"},   64'(bus.out_row), 0);
    chk({tag, "_col"},   64'(bus.out_col), 0);
  endtask

  // mode 0: ready high; 1: ready pattern 1,0,0,1; 2: random ready.
  task automatic run_stream(input string tag, input int mode, input bit perturb);
    logic [W-1:0] exp_q [$];
    logic         rdy;
    int           k;
    int           cyc;
    for (int i = 0; i < int'(N); i++) exp_q.push_back(ref_m[i]);
    load_mat();
    start = 1'b1;
    bus.out_ready = 1'b0;
    step();
    start = 1'b0;
    k   = 0;
    cyc = 0;
    while (k < int'(N) && cyc < 400) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (perturb) begin
        start = 1'($urandom_range(0, 1));
        for (int b = 0; b < int'(N); b++) mat_in[b*W +: W] = 8'($urandom);
      end
      bus.out_ready = rdy;
      chk({tag, "_valid"}, 64'(bus.out_valid), 1);
      chk({tag, "_busy"},  64'(busy), 1);
      chk({tag, "_done_early"}, 64'(done), 0);
      chk({tag, "_data"},  64'(bus.out_data), 64'(exp_q[k]));
      chk({tag, "_row"},   64'(bus.out_row), 64'(k / int'(COLS)));
      chk({tag, "_col"},   64'(bus.out_col), 64'(k % int'(COLS)));
      chk({tag, "_last"},  64'(bus.out_last), 64'(k == int'(N) - 1));
      step();
      if (rdy) k++;
      cyc++;
    end
    if (k < int'(N)) chk({tag, "_timeout"}, 64'(k), 64'(N));
    if (mode == 0) chk({tag, "_latency"}, 64'(cyc), 64'(N));
    start = 1'b0;
    bus.out_ready = 1'b0;
    chk({tag, "_done_pulse"}, 64'(done), 1);
    chk({tag, "_valid_after"}, 64'(bus.out_valid), 0);
    chk({tag, "_busy_after"}, 64'(busy), 0);
    step();
    chk({tag, "_done_clear"}, 64'(done), 0);
    chk({tag, "_idle_valid"}, 64'(bus.out_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{din: 8'hA5, stall: 0, exp_data: 8'hA5, exp_last: 1'b1};
    vecs[1] = '{din: 8'h00, stall: 2, exp_data: 8'h00, exp_last: 1'b1};
    vecs[2] = '{din: 8'hFF, stall: 0, exp_data: 8'hFF, exp_last: 1'b1};
    vecs[3] = '{din: 8'h3C, stall: 3, exp_data: 8'h3C, exp_last: 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    start1 = 1'b0;
    mat_in = '0;
    mat_in1 = '0;
    bus.out_ready = 1'b0;
    bus1.out_ready = 1'b0;
    #12;
    chk_zero("reset");
    chk("reset1_valid", 64'(bus1.out_valid), 0);
    chk("reset1_busy", 64'(busy1), 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < int'(N); i++) ref_m[i] = 8'(i + 1);
    run_stream("seq", 0, 1'b0);
    run_stream("stall", 1, 1'b0);
    run_stream("perturb", 0, 1'b1);

    // Reset after seven transfers aborts without done.
    for (int i = 0; i < int'(N); i++) ref_m[i] = 8'(i + 1);
    load_mat();
    start = 1'b1;
    step();
    start = 1'b0;
    bus.out_ready = 1'b1;
    repeat (7) step();
    chk("abort_pre_data", 64'(bus.out_data), 8);
    #1 rst_n = 1'b0;
    #1;
    chk_zero("abort");
    step();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_done", 64'(done), 0);
      chk("abort_no_resume", 64'(bus.out_valid), 0);
    end
    for (int i = 0; i < int'(N); i++) ref_m[i] = 8'hFF;
    run_stream("ff", 0, 1'b0);

    // start held high: DONE cycle plus one IDLE cycle between streams.
    for (int i = 0; i < int'(N); i++) ref_m[i] = 8'(8'h40 + i);
    load_mat();
    start = 1'b1;
    bus.out_ready = 1'b1;
    step();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < int'(N); k++) begin
        chk("b2b_valid", 64'(bus.out_valid), 1);
        chk("b2b_data", 64'(bus.out_data), 64'(ref_m[k]));
        step();
      end
      chk("b2b_done_cycle", 64'(done), 1);
      chk("b2b_done_valid", 64'(bus.out_valid), 0);
      if (s == 0) begin
        for (int i = 0; i < int'(N); i++) ref_m[i] = 8'(8'h80 + i);
        load_mat();
      end else begin
        start = 1'b0;
      end
      step();
      chk("b2b_idle_done", 64'(done), 0);
      chk("b2b_idle_valid", 64'(bus.out_valid), 0);
      chk("b2b_idle_busy", 64'(busy), 0);
      step();
    end
    chk("b2b_no_restart", 64'(bus.out_valid), 0);
    bus.out_ready = 1'b0;

    // Single-element matrix vectors.
    for (int v = 0; v < 4; v++) begin
      mat_in1 = vecs[v].din;
      start1 = 1'b1;
      bus1.out_ready = 1'b0;
      step();
      start1 = 1'b0;
      mat_in1 = ~vecs[v].din;
      for (int s = 0; s < vecs[v].stall; s++) begin
        chk("one_stall_data", 64'(bus1.out_data), 64'(vecs[v].exp_data));
        chk("one_stall_valid", 64'(bus1.out_valid), 1);
        step();
      end
      bus1.out_ready = 1'b1;
      chk("one_valid", 64'(bus1.out_valid), 1);
      chk("one_data", 64'(bus1.out_data), 64'(vecs[v].exp_data));
      chk("one_last", 64'(bus1.out_last), 64'(vecs[v].exp_last));
      chk("one_busy", 64'(busy1), 1);
      step();
      bus1.out_ready = 1'b0;
      chk("one_done", 64'(done1), 1);
      chk("one_valid_after", 64'(bus1.out_valid), 0);
      step();
      chk("one_done_clear", 64'(done1), 0);
    end

    // Randomized streams against the reference queue.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < int'(N); i++) ref_m[i] = 8'($urandom);
      run_stream("rand", 2, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
